// File: rtl/rate_pkg.sv
// Shared types and constants for the divider rate scheduler.
// Holds the FSM state encoding, the tap-code type and the wait-counter sizing.
package rate_pkg;

    localparam int unsigned TIMEOUT_DEF = 8192;
    localparam int unsigned WAIT_W      = 14;

    // 00 selects /2^10 up to 11 selecting /2^13.
    typedef logic [1:0] tap_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WAIT_FALL,
        DONE
    } state_t;

    function automatic logic [1:0] grant_vec(input logic winner);
        return winner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rate_sched_if.sv
// Request/grant and divider signals between the rate scheduler and its clients.
// The master side owns requests and the divider output; the slave side is the scheduler.
interface rate_sched_if;
    import rate_pkg::*;

    logic [1:0] req;
    tap_t       sel_a;
    tap_t       sel_b;
    logic       div_out;
    tap_t       load;
    logic [1:0] ack;
    logic       forced;
    logic       busy;

    modport master (
        output req, sel_a, sel_b, div_out,
        input  load, ack, forced, busy
    );

    modport slave (
        input  req, sel_a, sel_b, div_out,
        output load, ack, forced, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the pointed-to requester wins when active,
// otherwise the other one does (only meaningful while req is non-zero).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       winner
);

    assign winner = req[rr_ptr] ? rr_ptr : ~rr_ptr;

endmodule

// File: rtl/rate_sched.sv
// Arbitrates tap-change requests and applies the new tap on a falling edge of
// the divided clock, forcing the change if no edge arrives within TIMEOUT cycles.
module rate_sched
    import rate_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input logic         clk,
    input logic         rst,
    rate_sched_if.slave bus
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

    state_t            state;
    tap_t              sel_pend;
    logic              rr_ptr;
    logic              winner;
    logic              winner_q;
    logic              div_q;
    logic              fall;
    logic [WAIT_W-1:0] wait_cnt;

    rr_arb2 u_arb (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .winner (winner)
    );

    assign fall = div_q & ~bus.div_out;

    // NOTE: all state here uses <= so every flop samples pre-edge values,
    // and the async reset branch sits first so rst wins without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bus.load   <= '0;
            bus.ack    <= '0;
            bus.forced <= 1'b0;
            bus.busy   <= 1'b0;
            rr_ptr     <= 1'b0;
            winner_q   <= 1'b0;
            div_q      <= 1'b0;
            wait_cnt   <= '0;
            sel_pend   <= '0;
        end else begin
            div_q      <= bus.div_out;
            bus.ack    <= '0;
            bus.forced <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        winner_q <= winner;
                        sel_pend <= winner ? bus.sel_b : bus.sel_a;
                        bus.busy <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (sel_pend == bus.load) begin
                        bus.ack <= grant_vec(winner_q);
                        state   <= DONE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
                    // A real edge beats a simultaneous timeout, so forced follows ~fall.
                    if (fall || wait_cnt == WAIT_LAST) begin
                        bus.load   <= sel_pend;
                        bus.ack    <= grant_vec(winner_q);
                        bus.forced <= ~fall;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr   <= ~winner_q;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rate_sched.sv
// Randomized bench for rate_sched: a transaction-level reference model predicts
// the completion cycle, grant, forced flag and resulting tap of every request.
module tb_rate_sched;
    import rate_pkg::*;

    localparam int TB_TIMEOUT = 16;
    localparam int WAVE_N     = 4096;
    localparam int RAND_START = 300;
    localparam int RAND_END   = 3300;

    logic clk = 1'b0;
    logic rst;

    rate_sched_if bus ();

    rate_sched #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic div_wave [WAVE_N];
    bit   auto_req;

    // Reference model: one transaction at a time, timed in rising-edge numbers.
    int   m_start, m_done, m_idle_from;
    bit   m_win, m_rr, m_forced;
    tap_t m_sel, m_load;

    bit         ack_seen;
    logic [1:0] ack_val;
    int         ack_cyc;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_start = -1; m_done = -2; m_idle_from = 0;
        m_rr = 1'b0; m_load = 2'b00; m_forced = 1'b0; m_win = 1'b0; m_sel = 2'b00;
    endtask

    // Called just after rising edge `cyc`: decide whether a request launches
    // here and, if so, find the edge at which it completes.
    task automatic model_edge();
        logic [1:0] r;
        bit w;
        r = bus.req;
        if (cyc >= m_idle_from && r != 2'b00) begin
            w = r[m_rr] ? m_rr : !m_rr;
            m_win = w;
            m_sel = w ? bus.sel_b : bus.sel_a;
            m_rr = !w;
            m_start = cyc;
            if (m_sel == m_load) begin
                m_done = cyc + 1;
                m_forced = 1'b0;
            end else begin
                for (int j = 0; j < TB_TIMEOUT; j++) begin
                    int m;
                    m = cyc + 2 + j;
                    if (div_wave[m-1] && !div_wave[m]) begin
                        m_done = m; m_forced = 1'b0;
                        break;
                    end
                    if (j == TB_TIMEOUT - 1) begin
                        m_done = m; m_forced = 1'b1;
                    end
                end
            end
            m_idle_from = m_done + 2;
        end
    endtask

    task automatic drive_requesters();
        for (int i = 0; i < 2; i++) begin
            if (bus.ack[i]) begin
                bus.req[i] = 1'b0;
            end else if (auto_req) begin
                if ((!bus.req[i] && $urandom_range(0, 3) == 0) || $urandom_range(0, 7) == 0) begin
                    bus.req[i] = 1'b1;
                    if (i == 0) bus.sel_a = 2'($urandom_range(0, 3));
                    else        bus.sel_b = 2'($urandom_range(0, 3));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        if (cyc == m_done) m_load = m_sel;
        check("busy",   int'(bus.busy),   int'(cyc >= m_start && cyc <= m_done));
        check("ack",    int'(bus.ack),    (cyc == m_done) ? (1 << m_win) : 0);
        check("forced", int'(bus.forced), int'(cyc == m_done && m_forced));
        check("load",   int'(bus.load),   int'(m_load));
        if (bus.ack != 2'b00) begin
            ack_seen = 1'b1; ack_val = bus.ack; ack_cyc = cyc;
        end
        drive_requesters();
        bus.div_out = div_wave[cyc+1];
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check("rst_busy",   int'(bus.busy),   0);
            check("rst_load",   int'(bus.load),   0);
            check("rst_ack",    int'(bus.ack),    0);
            check("rst_forced", int'(bus.forced), 0);
            bus.div_out = div_wave[cyc+1];
        end
    endtask

    task automatic wait_ack(input int limit, output logic [1:0] val, output int at);
        ack_seen = 1'b0;
        for (int i = 0; i < limit && !ack_seen; i++) step();
        check("ack_wait_expired", int'(ack_seen), 1);
        val = ack_val;
        at  = ack_cyc;
    endtask

    task automatic idle_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic fill(input int lo, input int hi, input logic v);
        for (int i = lo; i <= hi; i++) div_wave[i] = v;
    endtask

    task automatic build_wave();
        int  i;
        bit  v;
        fill(0, RAND_START - 1, 1'b0);
        fill(20, 39, 1'b1);                       // single fall sampled at edge 40
        fill(45, 97, 1'b1);                       // long high, then fall at edge 98
        for (int k = 111; k <= 199; k++) div_wave[k] = k[1];
        fill(200, 241, 1'b1);
        for (int k = 242; k < RAND_START; k++) div_wave[k] = k[1];
        i = RAND_START;
        v = 1'b0;
        while (i < WAVE_N) begin
            int len;
            len = $urandom_range(1, 24);
            for (int j = 0; j < len && i < WAVE_N; j++) begin
                div_wave[i] = v;
                i++;
            end
            v = !v;
        end
    endtask

    initial begin
        logic [1:0] v1, v2;
        int a1, a2, c0, launch;

        rst = 1'b1;
        bus.req = 2'b00; bus.sel_a = 2'b00; bus.sel_b = 2'b00; bus.div_out = 1'b0;
        auto_req = 1'b0;
        build_wave();
        model_reset();
        hold_reset(2);
        #1 rst = 1'b0;

        // Same-code request: no divider change, grant two cycles after req.
        bus.req = 2'b01; bus.sel_a = 2'b00;
        c0 = cyc;
        wait_ack(10, v1, a1);
        check("same_latency", a1 - c0, 2);
        check("same_ack",     int'(v1), 1);
        check("same_load",    int'(bus.load), 0);
        check("same_forced",  int'(bus.forced), 0);

        // Edge-aligned switch: div_out first sampled low at edge 40.
        idle_until(29);
        bus.req = 2'b10; bus.sel_b = 2'b11;
        wait_ack(30, v1, a1);
        check("edge_cycle",  a1, 40);
        check("edge_ack",    int'(v1), 2);
        check("edge_load",   int'(bus.load), 3);
        check("edge_forced", int'(bus.forced), 0);

        // Timeout with div_out held high.
        idle_until(50);
        bus.req = 2'b01; bus.sel_a = 2'b10;
        launch = cyc + 1;
        wait_ack(40, v1, a1);
        check("to_wait_cycles", a1 - (launch + 2) + 1, 16);
        check("to_ack",    int'(v1), 1);
        check("to_load",   int'(bus.load), 2);
        check("to_forced", int'(bus.forced), 1);

        // Fall sampled on the same cycle the wait count hits TIMEOUT-1.
        idle_until(80);
        bus.req = 2'b10; bus.sel_b = 2'b00;
        wait_ack(40, v1, a1);
        check("tie_cycle",  a1, 98);
        check("tie_ack",    int'(v1), 2);
        check("tie_load",   int'(bus.load), 0);
        check("tie_forced", int'(bus.forced), 0);

        // Round-robin with both requesters held.
        idle_until(120);
        bus.req = 2'b11; bus.sel_a = 2'b01; bus.sel_b = 2'b10;
        wait_ack(40, v1, a1);
        wait_ack(40, v2, a2);
        check("rr_first",  int'(v1), 1);
        check("rr_second", int'(v2), 2);

        // Leave the pointer at requester 1, then reset mid-WAIT_FALL.
        idle_until(200);
        bus.req = 2'b01; bus.sel_a = 2'b11;
        wait_ack(40, v1, a1);
        check("pre_rst_load", int'(bus.load), 3);
        idle_until(230);
        bus.req = 2'b10; bus.sel_b = 2'b01;
        idle_until(237);
        #1 rst = 1'b1;
        #1;
        check("rst_async_load", int'(bus.load), 0);
        check("rst_async_ack",  int'(bus.ack), 0);
        check("rst_async_busy", int'(bus.busy), 0);
        model_reset();
        bus.req = 2'b00;
        hold_reset(2);
        #1 rst = 1'b0;
        ack_seen = 1'b0;
        repeat (10) step();
        check("rst_no_ack", int'(ack_seen), 0);

        bus.req = 2'b11; bus.sel_a = 2'b10; bus.sel_b = 2'b01;
        wait_ack(40, v1, a1);
        check("rr_after_rst", int'(v1), 1);
        wait_ack(40, v2, a2);
        check("rr_after_rst_second", int'(v2), 2);

        // Randomized traffic against the model.
        idle_until(RAND_START);
        auto_req = 1'b1;
        idle_until(RAND_END);
        auto_req = 1'b0;
        repeat (2 * TB_TIMEOUT + 10) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rate_sched.md
RATE_SCHED -- requirements
Module: rate_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8192, meaning the maximum clk cycles to wait for a divider falling edge before forcing a rate change.
REQ-002 The block SHALL have input clk, 1 bit: system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have input req, 2 bits: rate-change request, one bit per requester (0, 1), level.
REQ-005 The block SHALL have inputs sel_a and sel_b, 2 bits each: tap code requested by requester 0 and 1 (00=/2^10 … 11=/2^13).
REQ-006 The block SHALL have input div_out, 1 bit: the divider output, registered in the clk domain.
REQ-007 The block SHALL have output load, 2 bits: tap-select code driven to the divider.
REQ-008 The block SHALL have output ack, 2 bits: one-cycle grant-complete pulse per requester.
REQ-009 The block SHALL have output forced, 1 bit: pulses with ack when the change was applied by timeout.
REQ-010 The block SHALL have output busy, 1 bit: high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, CHECK, WAIT_FALL and DONE.
REQ-012 IDLE with req!=0 SHALL select a winner, latch the winner's sel as sel_pend and go to CHECK; otherwise it stays in IDLE.
REQ-013 Winner selection SHALL be round-robin: winner=rr_ptr if req[rr_ptr], else the other requester.
REQ-014 CHECK SHALL go to DONE when sel_pend==load (no divider change) and to WAIT_FALL otherwise, clearing wait_cnt.
REQ-015 WAIT_FALL SHALL detect a falling edge as div_q==1 and div_out==0, where div_q is div_out delayed one clk.
REQ-016 On a detected falling edge, the edge leaving WAIT_FALL SHALL set load<=sel_pend and enter DONE, so the tap switches only while the divided clock is low.
REQ-017 If wait_cnt reaches TIMEOUT-1 with no falling edge, the block SHALL set load<=sel_pend, set forced for the DONE cycle and enter DONE.
REQ-018 When the falling edge and the timeout occur in the same cycle, the edge SHALL take priority and forced SHALL stay 0.
REQ-019 wait_cnt SHALL be 14 bits, increment once per WAIT_FALL cycle and never wrap.
REQ-020 In DONE, ack[winner] SHALL be 1 for exactly one cycle and rr_ptr SHALL become the non-winner; the next state is IDLE.
REQ-021 ack and forced SHALL be registered outputs, 0 in all states other than DONE.
REQ-022 A requester SHALL drop req on the edge at which it samples ack=1; a req still high in IDLE after that edge is a new request.
REQ-023 Latency SHALL be ack 2 cycles after req is sampled for a same-code request, and 2 cycles plus the WAIT_FALL cycles otherwise.
REQ-024 Changes on req, sel_a or sel_b outside IDLE SHALL be ignored; sel_pend stays frozen until DONE.

Reset
REQ-025 While rst is high, the block SHALL force state=IDLE, load=00, ack=00, forced=0, busy=0, rr_ptr=0, div_q=0, wait_cnt=0 and sel_pend=00, asynchronously.
REQ-026 Reset mid-operation SHALL discard the pending request with no ack, and load SHALL return to 00 immediately.

Structure
REQ-027 Package rate_pkg SHALL hold the FSM state enum, the 2-bit tap-code typedef, and the TIMEOUT default and wait_cnt width constants.
REQ-028 Round-robin selection SHALL be the sub-module rr_arb2 (inputs req and rr_ptr, output winner); all other logic stays in rate_sched.

Verification
REQ-029 The bench SHALL check reset: with rst high mid-WAIT_FALL, expect load=00, ack=00 and busy=0 at once, and no ack after release.
REQ-030 The bench SHALL check the same-code case: load=00, req=01, sel_a=00; expect ack=01 exactly 2 cycles later, load unchanged, forced=0.
REQ-031 The bench SHALL check edge-aligned switching: req=10, sel_b=11, div_out falling at cycle 40; expect load=11 and ack=10 on the edge after the fall is sampled, forced=0.
REQ-032 The bench SHALL check timeout: TIMEOUT=16, div_out held high, req=01, sel_a=10; expect load=10, ack=01 and forced=1 after 16 WAIT_FALL cycles.
REQ-033 The bench SHALL check round-robin: req=11 held, with each requester dropping its req on its own ack; expect ack order 01 then 10, and after reset with req=11 again, 01 first.
REQ-034 The bench SHALL check simultaneous edge and timeout: the fall is sampled in the same cycle wait_cnt=TIMEOUT-1; expect forced=0.
